quadrature_decoder: RTL and testbench

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

---
 rtl/quadrature_decoder_pkg.sv | 13 +
 rtl/quadrature_decoder_if.sv | 9 +
 rtl/input_filter.sv | 40 ++++
 rtl/quadrature_decoder.sv | 63 ++++++
 tb/tb_quadrature_decoder.sv | 120 ++++++++++++
 5 files changed

// File: rtl/quadrature_decoder_pkg.sv
// quadrature_decoder_pkg: Gray position codes, step direction codes and filter length bounds.
package quadrature_decoder_pkg;
    localparam int FILTER_LEN_MIN = 1;
    localparam int FILTER_LEN_MAX = 15;
    typedef enum logic [1:0] {POS0 = 2'b00, POS1 = 2'b10, POS2 = 2'b11, POS3 = 2'b01} pos_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_ERR} dir_e;
    function automatic pos_e next_fwd(pos_e p);
        return p == POS0 ? POS1 : p == POS1 ? POS2 : p == POS2 ? POS3 : POS0;
    endfunction
    function automatic dir_e decode(pos_e p, pos_e n);
        return n == p ? DIR_NONE : n == next_fwd(p) ? DIR_UP : p == next_fwd(n) ? DIR_DOWN : DIR_ERR;
    endfunction
endpackage

// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if: channel, load and count/pulse signals of the quadrature decoder.
interface quadrature_decoder_if #(parameter int WIDTH = 8);
    logic a, b, load;
    logic [WIDTH-1:0] in;
    logic up, down, err, cout, bout;
    logic [WIDTH-1:0] count;
    modport master (output a, b, load, in, input up, down, err, count, cout, bout);
    modport slave (input a, b, load, in, output up, down, err, count, cout, bout);
endinterface

// File: rtl/input_filter.sv
// input_filter: two-flop synchronizer plus run-length level filter for one channel.
module input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic vld
);
    localparam logic [4:0] LAST = 5'(FILTER_LEN - 1);
    localparam logic [4:0] INIT = 5'(FILTER_LEN + 1);
    logic [1:0] sync_q, sync_d;
    logic [4:0] cnt_q, cnt_d;
    logic flt_q, flt_d, vld_q, vld_d, diff, hit;
    // Until valid, the counter just waits out the synchronizer and filter depth, then adopts the level.
    always_comb begin
        sync_d = {sync_q[0], d};
        diff = sync_q[1] != flt_q;
        hit = vld_q ? diff && cnt_q == LAST : cnt_q == INIT;
        cnt_d = hit || (vld_q && !diff) ? '0 : cnt_q + 5'd1;
        flt_d = hit ? sync_q[1] : flt_q;
        vld_d = vld_q || hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q <= '0;
            flt_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            flt_q <= flt_d;
            vld_q <= vld_d;
        end
    end
    assign q = flt_q;
    assign vld = vld_q;
endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: filtered A/B quadrature decode into up/down/error pulses and a wrapping position count.
module quadrature_decoder
    import quadrature_decoder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FILTER_LEN = 4
) (
    input logic clk,
    input logic rst,
    quadrature_decoder_if.slave bus
);
    if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
        $error("FILTER_LEN out of range");
    end
    logic fa, fb, va, vb;
    input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .rst(rst), .d(bus.a), .q(fa), .vld(va));
    input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .rst(rst), .d(bus.b), .q(fb), .vld(vb));
    pos_e p_q, p_d, n;
    dir_e dir;
    logic p_vld_q, p_vld_d;
    logic up_q, up_d, down_q, down_d, err_q, err_d, cout_q, cout_d, bout_q, bout_d;
    logic [WIDTH-1:0] count_q, count_d;
    // The first valid pair only seeds P; decoding starts once P holds a real position.
    always_comb begin
        n = pos_e'({fa, fb});
        dir = p_vld_q && va && vb ? decode(p_q, n) : DIR_NONE;
        p_d = va && vb ? n : p_q;
        p_vld_d = p_vld_q || (va && vb);
        up_d = dir == DIR_UP;
        down_d = dir == DIR_DOWN;
        err_d = dir == DIR_ERR;
        count_d = bus.load ? bus.in : up_d ? count_q + WIDTH'(1) : down_d ? count_q - WIDTH'(1) : count_q;
        cout_d = !bus.load && up_d && &count_q;
        bout_d = !bus.load && down_d && count_q == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= POS0;
            p_vld_q <= 1'b0;
            up_q <= 1'b0;
            down_q <= 1'b0;
            err_q <= 1'b0;
            cout_q <= 1'b0;
            bout_q <= 1'b0;
            count_q <= '0;
        end else begin
            p_q <= p_d;
            p_vld_q <= p_vld_d;
            up_q <= up_d;
            down_q <= down_d;
            err_q <= err_d;
            cout_q <= cout_d;
            bout_q <= bout_d;
            count_q <= count_d;
        end
    end
    assign bus.up = up_q;
    assign bus.down = down_q;
    assign bus.err = err_q;
    assign bus.cout = cout_q;
    assign bus.bout = bout_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed quadrature steps, glitches, wraps, loads and resets with fixed expectations.
module tb_quadrature_decoder;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    quadrature_decoder_if #(.WIDTH(8)) bus ();
    quadrature_decoder #(.WIDTH(8), .FILTER_LEN(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_checks = 0, n_errors = 0, n_up = 0, n_down = 0, n_err = 0;
    always @(posedge clk) begin
        #2;
        n_up += int'(bus.up);
        n_down += int'(bus.down);
        n_err += int'(bus.err);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [4:0] pulses();
        return {bus.up, bus.down, bus.err, bus.cout, bus.bout};
    endfunction
    // Pulse {up,down,err,cout,bout} must land exactly L+3 edges after the change and last one cycle.
    task automatic step(input logic na, input logic nb, input logic [4:0] exp, input string tag);
        logic [4:0] early = '0;
        bus.a = na;
        bus.b = nb;
        repeat (L + 2) begin
            @(negedge clk);
            early |= pulses();
        end
        @(negedge clk);
        check({tag, "_early"}, early, 0);
        check(tag, pulses(), exp);
        @(negedge clk);
        check({tag, "_width"}, pulses(), 0);
        repeat (2) @(negedge clk);
    endtask
    initial begin
        rst = 1'b1;
        bus.a = 1'b0;
        bus.b = 1'b0;
        bus.load = 1'b0;
        bus.in = '0;
        repeat (2) @(negedge clk);
        check("reset_out", {bus.count, pulses()}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_count", bus.count, 0);
        check("idle_pulses", n_up + n_down + n_err, 0);
        step(1'b1, 1'b0, 5'b10000, "fwd1");
        step(1'b1, 1'b1, 5'b10000, "fwd2");
        step(1'b0, 1'b1, 5'b10000, "fwd3");
        step(1'b0, 1'b0, 5'b10000, "fwd4");
        check("fwd_count", bus.count, 4);
        check("fwd_up", n_up, 4);
        check("fwd_down_err", n_down + n_err, 0);
        bus.load = 1'b1;
        bus.in = 8'hFF;
        @(negedge clk);
        bus.load = 1'b0;
        check("load", bus.count, 8'hFF);
        step(1'b1, 1'b0, 5'b10010, "wrap_up");
        check("wrap_up_count", bus.count, 8'h00);
        step(1'b0, 1'b0, 5'b01001, "wrap_down");
        check("wrap_down_count", bus.count, 8'hFF);
        bus.a = 1'b1;
        repeat (3) @(negedge clk);
        bus.a = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_pulses", n_up + n_down + n_err, 6);
        check("glitch_count", bus.count, 8'hFF);
        step(1'b1, 1'b0, 5'b10010, "level4");
        check("level4_count", bus.count, 8'h00);
        step(1'b0, 1'b0, 5'b01001, "back0");
        step(1'b1, 1'b1, 5'b00100, "both");
        check("both_count", bus.count, 8'hFF);
        step(1'b0, 1'b1, 5'b10010, "after_err");
        check("after_err_count", bus.count, 8'h00);
        bus.a = 1'b1;
        bus.b = 1'b1;
        rst = 1'b1;
        bus.load = 1'b1;
        bus.in = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_over_load", bus.count, 0);
        rst = 1'b0;
        bus.load = 1'b0;
        repeat (20) @(negedge clk);
        check("rst11_pulses", n_up + n_down + n_err, 10);
        check("rst11_count", bus.count, 0);
        step(1'b0, 1'b1, 5'b10000, "post_rst_up");
        check("post_rst_count", bus.count, 1);
        bus.b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_pulses", n_up + n_down + n_err, 11);
        check("mid_rst_count", bus.count, 0);
        bus.load = 1'b1;
        bus.in = 8'hFF;
        @(negedge clk);
        bus.load = 1'b0;
        bus.a = 1'b1;
        repeat (L + 2) @(negedge clk);
        bus.load = 1'b1;
        bus.in = 8'h42;
        @(negedge clk);
        bus.load = 1'b0;
        check("load_step_pulse", pulses(), 5'b10000);
        check("load_step_count", bus.count, 8'h42);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
